// File: rtl/heart_beat_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : heart_beat_counter_if
//  Description : Signal bundle between the heartbeat counter and its user.
//                The master side drives enable, raw sensor pulse and the
//                window-expired level; the slave side (the counter) returns
//                beat strobe, count, bpm result and status.
//  Revision    : 1.0  initial release
// ============================================================================
interface heart_beat_counter_if #(
   parameter int CNT_W = 8,
   parameter int BPM_W = 9
);
   logic             en_cont;
   logic             pulse_in;
   logic             window_done;
   logic             beat;
   logic [CNT_W-1:0] beat_count;
   logic [BPM_W-1:0] bpm;
   logic             bpm_valid;
   logic             busy;
   logic             overflow;

   modport master (
      output en_cont,
      output pulse_in,
      output window_done,
      input  beat,
      input  beat_count,
      input  bpm,
      input  bpm_valid,
      input  busy,
      input  overflow
   );

   modport slave (
      input  en_cont,
      input  pulse_in,
      input  window_done,
      output beat,
      output beat_count,
      output bpm,
      output bpm_valid,
      output busy,
      output overflow
   );
endinterface
`default_nettype wire

// File: rtl/heart_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : heart_beat_counter
//  Description : Counts refractory-filtered heartbeat pulses during a
//                measurement window, then converts the count to beats per
//                minute with a serial subtract-and-count divider.
//                Raw pulse and window-done inputs are resynchronised here.
//  Revision    : 1.0  initial release
// ============================================================================
module heart_beat_counter #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int WINDOW_S   = 40,
   parameter int REFRACT_MS = 250,
   parameter int CNT_W      = 8,
   parameter int BPM_W      = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   heart_beat_counter_if.slave  bus
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_REFRACT_CYC = CLK_HZ / 1000 * REFRACT_MS;
   // The counter only ever holds REFRACT_CYC-1 down to 0.
   localparam int c_REFR_W      = (c_REFRACT_CYC > 1) ? $clog2(c_REFRACT_CYC) : 1;
   // 60 < 2^6, so count*60 fits in CNT_W+6 bits.
   localparam int c_DIV_W       = CNT_W + 6;

   localparam logic [c_REFR_W-1:0] c_REFR_LOAD = c_REFR_W'(c_REFRACT_CYC - 1);
   localparam logic [c_DIV_W-1:0]  c_WINDOW    = c_DIV_W'(WINDOW_S);
   localparam logic [c_DIV_W-1:0]  c_SIXTY     = c_DIV_W'(60);
   localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
   localparam logic [BPM_W-1:0]    c_BPM_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_CALC    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_next;

   logic                r_pulse_meta;
   logic                r_pulse_s;
   logic                r_pulse_d;
   logic                r_wdone_meta;
   logic                r_wdone_s;

   logic [c_REFR_W-1:0] r_refr;
   logic                r_beat;
   logic [CNT_W-1:0]    r_beat_count;
   logic                r_overflow;

   logic [c_DIV_W-1:0]  r_dividend;
   logic [BPM_W-1:0]    r_quot;
   logic [BPM_W-1:0]    r_bpm;

   logic                w_candidate;
   logic                w_refr_zero;
   logic                w_accept;
   logic                w_cnt_sat;
   logic [CNT_W-1:0]    w_count_next;
   logic [c_DIV_W-1:0]  w_div_load;
   logic                w_div_ge;
   logic                w_busy;
   logic                w_bpm_valid;

   // -------------------------------------------------------------------------
   // Two-flop synchronisers for the asynchronous inputs, plus a delayed copy
   // of the synchronised pulse for rising-edge detection.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pulse_meta <= 1'b0;
         r_pulse_s    <= 1'b0;
         r_pulse_d    <= 1'b0;
         r_wdone_meta <= 1'b0;
         r_wdone_s    <= 1'b0;
      end else begin
         r_pulse_meta <= bus.pulse_in;
         r_pulse_s    <= r_pulse_meta;
         r_pulse_d    <= r_pulse_s;
         r_wdone_meta <= bus.window_done;
         r_wdone_s    <= r_wdone_meta;
      end
   end

   // -------------------------------------------------------------------------
   // Beat qualification and next-count arithmetic
   // -------------------------------------------------------------------------
   assign w_candidate  = r_pulse_s & ~r_pulse_d;
   assign w_refr_zero  = (r_refr == '0);
   // Beats only count while measuring and still enabled; an abort cycle
   // must not register a beat.
   assign w_accept     = (r_state == S_MEASURE) && bus.en_cont && w_candidate && w_refr_zero;
   assign w_cnt_sat    = (r_beat_count == c_CNT_MAX);
   assign w_count_next = (w_accept && !w_cnt_sat) ? (r_beat_count + CNT_W'(1)) : r_beat_count;
   // Uses the next count so a beat accepted in the same cycle as window
   // expiry is part of the result.
   assign w_div_load   = c_DIV_W'(w_count_next) * c_SIXTY;
   assign w_div_ge     = (r_dividend >= c_WINDOW);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and state-decoded status outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_bpm_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.en_cont) begin
               w_state_next = S_MEASURE;
            end
         end
         S_MEASURE: begin
            w_busy = 1'b1;
            if (!bus.en_cont) begin
               w_state_next = S_IDLE;
            end else if (r_wdone_s) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            w_busy = 1'b1;
            if (!bus.en_cont) begin
               w_state_next = S_IDLE;
            end else if (!w_div_ge) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_bpm_valid = 1'b1;
            if (!bus.en_cont) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Beat strobe, saturating beat counter, overflow flag and refractory timer.
   // Everything is cleared on the way into IDLE so an aborted window leaves
   // no residue.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat       <= 1'b0;
         r_beat_count <= '0;
         r_overflow   <= 1'b0;
         r_refr       <= '0;
      end else begin
         r_beat <= w_accept;
         if (w_state_next == S_IDLE) begin
            r_beat_count <= '0;
            r_overflow   <= 1'b0;
            r_refr       <= '0;
         end else begin
            r_beat_count <= w_count_next;
            if (w_accept && w_cnt_sat) begin
               r_overflow <= 1'b1;
            end
            if (w_accept) begin
               r_refr <= c_REFR_LOAD;
            end else if (!w_refr_zero) begin
               r_refr <= r_refr - c_REFR_W'(1);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Serial divider: dividend loaded on the MEASURE->CALC edge, one
   // subtraction of WINDOW_S per CALC cycle. bpm only updates when the
   // division completes, so an abort leaves the previous result intact.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dividend <= '0;
         r_quot     <= '0;
         r_bpm      <= '0;
      end else if ((r_state == S_MEASURE) && (w_state_next == S_CALC)) begin
         r_dividend <= w_div_load;
         r_quot     <= '0;
      end else if ((r_state == S_CALC) && bus.en_cont) begin
         if (w_div_ge) begin
            r_dividend <= r_dividend - c_WINDOW;
            if (r_quot != c_BPM_MAX) begin
               r_quot <= r_quot + BPM_W'(1);
            end
         end else begin
            r_bpm <= r_quot;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output drive
   // -------------------------------------------------------------------------
   assign bus.beat       = r_beat;
   assign bus.beat_count = r_beat_count;
   assign bus.overflow   = r_overflow;
   assign bus.bpm        = r_bpm;
   assign bus.bpm_valid  = w_bpm_valid;
   assign bus.busy       = w_busy;

endmodule
`default_nettype wire
